// File: rtl/mem_access_stage.sv
// EX/MEM pipeline stage: registers ALU results, runs data-memory loads/stores
// over a req/ack bus, and formats store lanes and load extension for writeback.

package mem_access_pkg;
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
endpackage

module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int RAW = 5,
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall_i,
  input  logic           flush_i,
  input  logic [RAW-1:0] ex_reg_waddr,
  input  logic           ex_we,
  input  logic [DW-1:0]  ex_reg_wdata,
  input  logic [OPW-1:0] ex_aluop,
  input  logic [AW-1:0]  ex_mem_addr,
  input  logic [DW-1:0]  ex_rt_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [AW-1:0]  dmem_addr,
  output logic [3:0]     dmem_be,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_ack,
  input  logic [DW-1:0]  dmem_rdata,
  output logic [RAW-1:0] mem_reg_waddr,
  output logic           mem_we,
  output logic [DW-1:0]  mem_reg_wdata,
  output logic           stallreq_mem,
  output logic           misalign
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  typedef struct packed {
    logic [RAW-1:0] waddr;
    logic           we;
    logic [DW-1:0]  wdata;
    logic [OPW-1:0] op;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  rt;
  } ex_mem_t;

  localparam ex_mem_t BUBBLE = '{waddr: '0, we: 1'b0, wdata: '0,
                                 op: EXE_NOP_OP, addr: '0, rt: '0};

  function automatic logic f_is_load(input logic [OPW-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
           (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
  endfunction

  function automatic logic f_is_store(input logic [OPW-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic f_misaligned(input logic [OPW-1:0] op, input logic [1:0] a);
    logic half, word;
    half = (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
    word = (op == EXE_LW_OP) || (op == EXE_SW_OP);
    return (half & a[0]) | (word & (a != 2'b00));
  endfunction

  state_e          state_q, state_d;
  ex_mem_t         stage_q, stage_d;
  logic            req_q, req_d;
  logic            kill_q, kill_d;
  logic            mis_q, mis_d;
  logic [DW-1:0]   load_q, load_d;

  logic            cap, ex_mem, ex_mis;
  logic [OPW-1:0]  cur_op;
  logic [1:0]      cur_a;
  logic [DW-1:0]   src;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [DW-1:0]   ld_res;

  assign cur_op       = stage_q.op;
  assign cur_a        = stage_q.addr[1:0];
  // The bus is busy until ack; holding the stage keeps the request stable.
  assign stallreq_mem = (state_q == S_WAIT) & ~dmem_ack;

  // State and stage registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      stage_q <= BUBBLE;
      req_q   <= 1'b0;
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      req_q   <= req_d;
      kill_q  <= kill_d;
      mis_q   <= mis_d;
      load_q  <= load_d;
    end
  end

  // Capture / next-state: a new aligned mem op issues its request at the
  // capture edge, which also covers leaving WAIT or HOLD back-to-back.
  always_comb begin
    cap     = ~stall_i & ~stallreq_mem;
    ex_mem  = f_is_load(ex_aluop) | f_is_store(ex_aluop);
    ex_mis  = f_misaligned(ex_aluop, ex_mem_addr[1:0]);
    stage_d = stage_q;
    state_d = state_q;
    req_d   = 1'b0;
    kill_d  = kill_q;
    mis_d   = 1'b0;
    load_d  = load_q;
    if (cap) begin
      kill_d = 1'b0;
      if (flush_i) begin
        stage_d = BUBBLE;
        state_d = S_IDLE;
      end else begin
        stage_d = '{waddr: ex_reg_waddr, we: ex_we, wdata: ex_reg_wdata,
                    op: ex_aluop, addr: ex_mem_addr, rt: ex_rt_data};
        mis_d   = ex_mem & ex_mis;
        req_d   = ex_mem & ~ex_mis;
        state_d = (ex_mem & ~ex_mis) ? S_WAIT : S_IDLE;
      end
    end else begin
      // A flush cannot withdraw a started bus cycle; remember to drop its result.
      if (flush_i && state_q != S_IDLE) kill_d = 1'b1;
      if (state_q == S_WAIT) begin
        if (dmem_ack) state_d = S_HOLD;
        else          req_d   = 1'b1;
      end
    end
    if (state_q == S_WAIT && dmem_ack) load_d = dmem_rdata;
  end

  // Bus-side formatting: byte enables and lane-replicated store data.
  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = '0;
    if (f_is_load(cur_op)) dmem_be = 4'b1111;
    case (cur_op)
      EXE_SB_OP: begin
        dmem_be    = 4'b0001 << cur_a;
        dmem_wdata = {4{stage_q.rt[7:0]}};
      end
      EXE_SH_OP: begin
        dmem_be    = cur_a[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{stage_q.rt[15:0]}};
      end
      EXE_SW_OP: begin
        dmem_be    = 4'b1111;
        dmem_wdata = stage_q.rt;
      end
      default: ;
    endcase
  end

  assign dmem_req  = req_q;
  assign dmem_we   = req_q & f_is_store(cur_op);
  assign dmem_addr = {stage_q.addr[AW-1:2], 2'b00};

  // Load extraction: live bus data on the ack cycle, latched copy while held.
  always_comb begin
    src     = (state_q == S_HOLD) ? load_q : dmem_rdata;
    ld_byte = src[{cur_a, 3'b000} +: 8];
    ld_half = src[{cur_a[1], 4'b0000} +: 16];
    case (cur_op)
      EXE_LB_OP:  ld_res = {{(DW-8){ld_byte[7]}}, ld_byte};
      EXE_LBU_OP: ld_res = {{(DW-8){1'b0}}, ld_byte};
      EXE_LH_OP:  ld_res = {{(DW-16){ld_half[15]}}, ld_half};
      EXE_LHU_OP: ld_res = {{(DW-16){1'b0}}, ld_half};
      default:    ld_res = src;
    endcase
  end

  // Writeback outputs; stores, misaligned ops, pending and killed loads never write.
  always_comb begin
    mem_reg_waddr = stage_q.waddr;
    mem_reg_wdata = f_is_load(cur_op) ? ld_res : stage_q.wdata;
    mem_we        = stage_q.we & ~f_misaligned(cur_op, cur_a) & ~stallreq_mem &
                    ~kill_q & ~f_is_store(cur_op);
  end

  assign misalign = mis_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute ALU; registers the EX results (EX/MEM boundary) and performs loads/stores to data memory over a req/ack handshake.
- Produces byte enables and lane-replicated store data, sign/zero-extends load data, and raises a stall request while a bus transaction is outstanding.
- Its outputs feed the writeback stage.

Parameters:
- DW, 32, register/data width (`RegBus).
- AW, 32, memory address width (`MemAddrBus).
- RAW, 5, register address width (`RegAddrBus).
- OPW, 8, aluop width (`AluOpBus).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  downstream or global stall from pipeline control.
- flush_i  in  1  kill the instruction held in this stage.
- ex_reg_waddr  in  RAW  destination register from EX.
- ex_we  in  1  register write enable from EX.
- ex_reg_wdata  in  DW  ALU result from EX.
- ex_aluop  in  OPW  operation code from EX.
- ex_mem_addr  in  AW  effective address from EX.
- ex_rt_data  in  DW  store source data from EX.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  1 = store.
- dmem_addr  out  AW  word-aligned address: addr[1:0] forced to 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  DW  lane-replicated store data.
- dmem_ack  in  1  transaction complete; rdata valid in the same cycle.
- dmem_rdata  in  DW  read word.
- mem_reg_waddr  out  RAW  to writeback.
- mem_we  out  1  to writeback.
- mem_reg_wdata  out  DW  to writeback.
- stallreq_mem  out  1  stall request to pipeline control.
- misalign  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All stage registers clear; captured aluop becomes `EXE_NOP_OP.
  - dmem_req, dmem_we, mem_we, stallreq_mem and misalign are 0.
  - dmem_be=0; all data and address outputs are 0.
  - Any in-flight transaction is abandoned.
- Capture: on each rising edge with stall_i=0 and stallreq_mem=0, the stage registers load the ex_* inputs.
  - If flush_i=1 at that edge, a bubble is captured instead: we=0, op=NOP.
- Mem ops: `EXE_LB/LH/LW/LBU/LHU_OP (loads) and `EXE_SB/SH/SW_OP (stores).
- Misaligned access:
  - Halfword ops with addr[0]=1, or word ops with addr[1:0]!=0.
  - misalign pulses for one cycle when the op is captured.
  - No request is issued; mem_we=0.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: a captured aligned mem op sets dmem_req=1 at the same edge as the capture; the FSM moves to WAIT.
  - WAIT: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable until dmem_ack.
    - stallreq_mem = (state==WAIT) & ~dmem_ack.
  - On ack: dmem_req drops at the next edge, and rdata is latched into load_q.
    - If stall_i=0, go to IDLE. A new mem op captured at that same edge re-asserts req, so back-to-back transfers have no idle cycle.
    - If stall_i=1, go to HOLD.
  - HOLD: outputs are driven from load_q; on stall_i=0, go to IDLE.
- Store byte enables and data:
  - SB: be = 1<<addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 when addr[1]=0, 1100 when addr[1]=1; wdata = half replicated ×2.
  - SW: be = 1111.
  - Loads: be = 1111, dmem_we=0.
- Load result, selected by addr[1:0] from the ack-cycle rdata (WAIT) or from load_q (HOLD):
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Outputs to writeback:
  - mem_reg_waddr is the captured waddr.
  - mem_we = captured we & ~misalign_cond & ~(state==WAIT & ~dmem_ack) & ~kill.
  - mem_reg_wdata is the load result for loads, else the captured reg_wdata.
  - Stores force mem_we=0.
- Flush during WAIT:
  - The request is not withdrawn; the bus handshake must complete.
  - kill is set, and on ack the result is discarded (mem_we=0). kill clears on leaving WAIT.
- dmem_ack outside WAIT is ignored.

Test Plan:
- ALU passthrough: aluop=ADD, waddr=5, wdata=0x1234, we=1 -> one cycle later mem_we=1, mem_reg_waddr=5, mem_reg_wdata=0x1234; dmem_req stays 0.
- LB at addr 0x103, ack after 3 cycles with rdata=0x80FF_0000 -> stallreq_mem high 3 cycles; dmem_addr=0x100, be=1111; ack-cycle mem_reg_wdata=0xFFFF_FF80, mem_we=1.
- SH at addr 0x202 with rt_data=0xABCD_5678 -> dmem_we=1, be=1100, dmem_wdata=0x5678_5678; mem_we=0 throughout.
- LW at addr 0x006 -> misalign pulses 1 cycle, dmem_req never asserts, mem_we=0, no stall.
- Ack with stall_i=1 for 2 cycles, LHU at addr 0x2, rdata=0xBEEF_0000 -> FSM enters HOLD, mem_reg_wdata stays 0x0000_BEEF until stall_i drops; LW then captured next edge with req re-asserted immediately.
- flush_i during WAIT, then ack -> req held until ack, mem_we=0; rst low mid-WAIT -> dmem_req=0 immediately (asynchronous), FSM in IDLE.
